delayf_tap_ctrl: RTL and testbench
==================================

# delayf_tap_ctrl

Synchronous command-driven controller that drives the LOADN/MOVE/DIRECTION pins of an ECP5 DELAYF input-delay element and consumes its CFLAG output. It keeps a shadow copy of the element's tap count and turns load, absolute-set, increment and decrement commands into correctly sequenced MOVE pulses, stopping at either end of the range. It sits between the I/O training logic (bitslip/eye-centering) and the DELAYF primitive on each delayed input.

## Interface
- TAP_W, 7: tap-count width; range 0 to 2^TAP_W-1.
- LOAD_VALUE, 0: tap count after LOADN; must equal the DELAYF DEL_VALUE.
- LOAD_CYCLES, 4: cycles LOADN is held low per load (>=1).
- MOVE_HIGH, 2: cycles MOVE is high per step (>=1).
- MOVE_GAP, 2: cycles MOVE is low after each pulse before the next step or done (>=1).

- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when valid && ready.
- cmd_op  in  2  00 LOAD, 01 SET (absolute), 10 INC, 11 DEC.
- cmd_tap  in  TAP_W  SET: target tap; INC/DEC: step count; ignored for LOAD.
- done  out  1  one-cycle pulse when a command completes.
- sat  out  1  range limit hit by the last command; cleared on the next accept.
- tap_cur  out  TAP_W  shadow tap count.
- delay_loadn  out  1  to DELAYF LOADN.
- delay_move  out  1  to DELAYF MOVE.
- delay_direction  out  1  to DELAYF DIRECTION; 0 = more delay, 1 = less delay.
- delay_cflag  in  1  from DELAYF CFLAG.

## Operation
- States: LOAD, IDLE, SETUP, PULSE, GAP, DONE. All outputs are registered.
- Reset: state=LOAD, cycle counter=0, delay_loadn=0, delay_move=0, delay_direction=0, tap_cur=LOAD_VALUE, sat=0, done=0, cmd_ready=0. The element is therefore always reloaded after reset.
- LOAD: delay_loadn=0 for LOAD_CYCLES cycles, then delay_loadn=1, tap_cur=LOAD_VALUE, go to DONE. A reset-entered LOAD goes to IDLE instead of DONE, so no done pulse is produced.
- Accept: cmd_op and cmd_tap are latched; sat is cleared. Remaining step count n and dir are set as follows:
  - SET: n = |cmd_tap - tap_cur|; dir = 1 if cmd_tap < tap_cur.
  - INC: n = cmd_tap; dir = 0.
  - DEC: n = cmd_tap; dir = 1.
  - n == 0 goes straight to DONE; otherwise go to SETUP.
- SETUP (1 cycle): delay_direction=dir, delay_move=0.
  - If the next step would leave the range (tap_cur at max with dir=0, or at 0 with dir=1) or delay_cflag==1: set sat=1 and go to DONE with no pulse.
  - Otherwise go to PULSE.
- PULSE (MOVE_HIGH cycles): delay_move=1; direction held.
- GAP (MOVE_GAP cycles): delay_move=0; direction held.
  - On the last GAP cycle: tap_cur += (dir ? -1 : +1) and n -= 1.
  - Then go to DONE if n==0, otherwise SETUP.
- DONE (1 cycle): done=1, then go to IDLE. delay_direction keeps its last value.
- Shadow arithmetic is unsigned TAP_W bits and never wraps; the range check happens before each pulse.
- cmd_valid outside IDLE is ignored; there is no queueing.

## Timing
- LOAD command: accepted at cycle 0; delay_loadn low in cycles 1..LOAD_CYCLES; DONE in cycle LOAD_CYCLES+1.
- After reset deassert, cmd_ready rises in cycle LOAD_CYCLES+1 (counting the first cycle with rst_n=1 as cycle 1).
- Each step takes S = 1+MOVE_HIGH+MOVE_GAP cycles (5 with defaults). The n-step command completes with DONE at cycle n*S+1 after accept.
- The DELAYF updates its count on MOVE falling edges. DIRECTION is stable from 1 cycle before MOVE rises until MOVE_GAP cycles after it falls.
- A zero-step command or an SET equal to tap_cur gives DONE in cycle 1 after accept.
- Reset asserted in any state takes effect on the next edge: delay_move=0 and delay_loadn=0 in the same cycle, followed by a full reload.
- delay_cflag is sampled only in SETUP. If CFLAG is high while the shadow is not at a limit, the command still stops with sat=1 and tap_cur is unchanged.

## Test plan
- Reset release, defaults: delay_loadn low for exactly 4 cycles, no done, cmd_ready=1 in cycle 5, tap_cur=0.
- SET 10 from 0: 10 MOVE pulses, each 2 cycles high with direction=0; done at cycle 51; tap_cur=10; sat=0; DELAYF model count=10.
- DEC 3 from 10: direction=1 one cycle before the first MOVE; 3 pulses; tap_cur=7; done at cycle 16.
- INC 5 from 125: 2 pulses, tap_cur=127, sat=1, done at cycle 12, DELAYF CFLAG=1. A follow-up SET 127 completes in 1 cycle with no pulse and sat=0.
- LOAD after SET 40, with LOAD_VALUE=0: delay_loadn low for 4 cycles, tap_cur=0, done at cycle 5; the model reports a 0-tap delay.
- Reset during PULSE of a SET 20 command: delay_move=0 on the next edge, the reload sequence runs, tap_cur=0, and no done pulse is produced.

Source files
------------

// File: rtl/delayf_tap_ctrl_if.sv
// delayf_tap_ctrl_if: command/status and DELAYF pin bundle between training logic and the tap controller.
interface delayf_tap_ctrl_if #(parameter int TAP_W = 7);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [TAP_W-1:0] cmd_tap;
    logic             done;
    logic             sat;
    logic [TAP_W-1:0] tap_cur;
    logic             delay_loadn;
    logic             delay_move;
    logic             delay_direction;
    logic             delay_cflag;
    modport master (
        output cmd_valid, cmd_op, cmd_tap, delay_cflag,
        input  cmd_ready, done, sat, tap_cur, delay_loadn, delay_move, delay_direction
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_tap, delay_cflag,
        output cmd_ready, done, sat, tap_cur, delay_loadn, delay_move, delay_direction
    );
endinterface

// File: rtl/delayf_tap_ctrl.sv
// delayf_tap_ctrl: sequences LOADN/MOVE/DIRECTION of an ECP5 DELAYF from load/set/inc/dec commands.
// Keeps a shadow tap count and stops at either end of the range or on CFLAG.
module delayf_tap_ctrl #(
    parameter int TAP_W       = 7,
    parameter int LOAD_VALUE  = 0,
    parameter int LOAD_CYCLES = 4,
    parameter int MOVE_HIGH   = 2,
    parameter int MOVE_GAP    = 2
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    delayf_tap_ctrl_if.slave bus
);
    localparam int CMAX  = (LOAD_CYCLES > MOVE_HIGH) ? ((LOAD_CYCLES > MOVE_GAP) ? LOAD_CYCLES : MOVE_GAP)
                                                     : ((MOVE_HIGH > MOVE_GAP) ? MOVE_HIGH : MOVE_GAP);
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(MOVE_HIGH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MOVE_GAP - 1);
    localparam logic [TAP_W-1:0] TAP_MAX   = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] TAP_LOAD  = TAP_W'(LOAD_VALUE);

    typedef enum logic [2:0] {LOAD, IDLE, SETUP, PULSE, GAP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] n;
    logic             dir;
    logic             boot;
    logic             set_dn;
    logic [TAP_W-1:0] acc_n;
    logic             acc_dir;
    logic             blocked;

    always_comb begin
        set_dn  = bus.cmd_tap < bus.tap_cur;
        acc_n   = bus.cmd_op[1] ? bus.cmd_tap
                : set_dn ? bus.tap_cur - bus.cmd_tap : bus.cmd_tap - bus.tap_cur;
        acc_dir = bus.cmd_op[1] ? bus.cmd_op[0] : set_dn;
        blocked = (dir ? bus.tap_cur == '0 : bus.tap_cur == TAP_MAX) || bus.delay_cflag;
    end

    // boot marks the reset-entered reload, which returns to IDLE without a done pulse
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state               <= LOAD;
            cnt                 <= '0;
            n                   <= '0;
            dir                 <= 1'b0;
            boot                <= 1'b1;
            bus.delay_loadn     <= 1'b0;
            bus.delay_move      <= 1'b0;
            bus.delay_direction <= 1'b0;
            bus.tap_cur         <= TAP_LOAD;
            bus.sat             <= 1'b0;
            bus.done            <= 1'b0;
            bus.cmd_ready       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                LOAD: begin
                    cnt <= (cnt == LOAD_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LOAD_LAST) begin
                        bus.delay_loadn <= 1'b1;
                        bus.tap_cur     <= TAP_LOAD;
                        boot            <= 1'b0;
                        state           <= boot ? IDLE : DONE;
                        bus.cmd_ready   <= boot;
                        bus.done        <= !boot;
                    end
                end
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        bus.sat       <= 1'b0;
                        cnt           <= '0;
                        n             <= acc_n;
                        dir           <= acc_dir;
                        if (bus.cmd_op == 2'b00) begin
                            state           <= LOAD;
                            bus.delay_loadn <= 1'b0;
                        end else if (acc_n == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state               <= SETUP;
                            bus.delay_direction <= acc_dir;
                        end
                    end
                end
                SETUP: begin
                    cnt            <= '0;
                    state          <= blocked ? DONE : PULSE;
                    bus.sat        <= blocked;
                    bus.done       <= blocked;
                    bus.delay_move <= !blocked;
                end
                PULSE: begin
                    cnt <= (cnt == HIGH_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == HIGH_LAST) begin
                        bus.delay_move <= 1'b0;
                        state          <= GAP;
                    end
                end
                GAP: begin
                    cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == GAP_LAST) begin
                        bus.tap_cur <= dir ? bus.tap_cur - 1'b1 : bus.tap_cur + 1'b1;
                        n           <= n - 1'b1;
                        state       <= (n == 1) ? DONE : SETUP;
                        bus.done    <= n == 1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_delayf_tap_ctrl.sv
// tb_delayf_tap_ctrl: directed and random commands against a DELAYF pin model and a command-level tap reference.
module tb_delayf_tap_ctrl;
    localparam int TAP_W = 7;
    localparam int TMAX  = 127;
    localparam int LV    = 0;
    localparam int LC    = 4;
    localparam int MH    = 2;
    localparam int MG    = 2;
    localparam int S     = 1 + MH + MG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cf_force = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ref_tap = LV;
    int   m_cnt = LV;
    logic m_prev_move = 1'b0;

    delayf_tap_ctrl_if #(.TAP_W(TAP_W)) bus ();

    delayf_tap_ctrl #(.TAP_W(TAP_W), .LOAD_VALUE(LV), .LOAD_CYCLES(LC), .MOVE_HIGH(MH), .MOVE_GAP(MG)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // DELAYF pin model: reload while LOADN low, count on MOVE falling edges, CFLAG at the range end
    assign bus.delay_cflag = cf_force | (bus.delay_direction ? (m_cnt == 0) : (m_cnt == TMAX));
    always @(posedge clk) begin
        m_prev_move <= bus.delay_move;
        if (!bus.delay_loadn)
            m_cnt <= LV;
        else if (m_prev_move && !bus.delay_move)
            m_cnt <= bus.delay_direction ? (m_cnt == 0 ? 0 : m_cnt - 1) : (m_cnt == TMAX ? TMAX : m_cnt + 1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic boot_check();
        int  lows = 0;
        int  cyc;
        bit  saw_done = 0;
        rst_n = 1'b1;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (!bus.delay_loadn) lows++;
            if (bus.done) saw_done = 1;
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        check("boot_loadn_cycles", lows, LC);
        check("boot_ready_cycle", cyc, LC + 1);
        check("boot_no_done", int'(saw_done), 0);
        check("boot_tap", int'(bus.tap_cur), LV);
        check("boot_sat", int'(bus.sat), 0);
        check("boot_model_cnt", m_cnt, LV);
        ref_tap = LV;
    endtask

    task automatic run_cmd(input logic [1:0] op, input int t, input bit fc);
        int   n, room, k, exp_done, exp_tap, cyc, pulses, hi, lows;
        bit   d, exp_sat;
        logic prev_move, prev_dir;
        n        = (op == 2'b00) ? 0 : (op == 2'b01) ? (t > ref_tap ? t - ref_tap : ref_tap - t) : t;
        d        = (op == 2'b11) || (op == 2'b01 && t < ref_tap);
        room     = d ? ref_tap : TMAX - ref_tap;
        k        = fc ? 0 : (n < room ? n : room);
        exp_sat  = n > 0 && k < n;
        exp_done = (op == 2'b00) ? LC + 1 : (n == 0) ? 1 : k * S + 1 + int'(exp_sat);
        exp_tap  = (op == 2'b00) ? LV : d ? ref_tap - k : ref_tap + k;
        for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
        check("ready_before_cmd", int'(bus.cmd_ready), 1);
        cf_force      = fc;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_tap   = TAP_W'(t);
        prev_move     = bus.delay_move;
        prev_dir      = bus.delay_direction;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        pulses = 0;
        hi     = 0;
        lows   = 0;
        for (cyc = 1; cyc <= 2000; cyc++) begin
            if (bus.delay_move && !prev_move) begin
                pulses++;
                check("dir_before_rise", int'(prev_dir), int'(d));
                check("dir_at_rise", int'(bus.delay_direction), int'(d));
                hi = 0;
            end
            if (bus.delay_move) hi++;
            if (!bus.delay_move && prev_move) check("move_width", hi, MH);
            if (!bus.delay_loadn) lows++;
            if (bus.done) break;
            prev_move = bus.delay_move;
            prev_dir  = bus.delay_direction;
            @(negedge clk);
        end
        cf_force = 1'b0;
        check("done_cycle", cyc, exp_done);
        check("pulses", pulses, k);
        check("loadn_cycles", lows, (op == 2'b00) ? LC : 0);
        check("tap_cur", int'(bus.tap_cur), exp_tap);
        check("sat", int'(bus.sat), int'(exp_sat));
        check("model_cnt", m_cnt, exp_tap);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);
        check("ready_after_done", int'(bus.cmd_ready), 1);
        ref_tap = exp_tap;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_tap   = '0;
        repeat (3) @(negedge clk);
        check("reset_loadn", int'(bus.delay_loadn), 0);
        check("reset_move", int'(bus.delay_move), 0);
        check("reset_ready", int'(bus.cmd_ready), 0);
        check("reset_done", int'(bus.done), 0);
        boot_check();

        run_cmd(2'b01, 10, 0);
        run_cmd(2'b11, 3, 0);
        run_cmd(2'b01, 125, 0);
        run_cmd(2'b10, 5, 0);
        run_cmd(2'b01, 127, 0);
        run_cmd(2'b01, 40, 0);
        run_cmd(2'b00, 0, 0);
        run_cmd(2'b11, 2, 0);
        run_cmd(2'b10, 0, 0);
        run_cmd(2'b01, 30, 1);
        run_cmd(2'b01, 30, 0);
        run_cmd(2'b10, 4, 1);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            int         t;
            op = 2'($urandom_range(0, 3));
            t  = (op == 2'b01) ? int'($urandom_range(0, TMAX)) : int'($urandom_range(0, 12));
            run_cmd(op, t, $urandom_range(0, 7) == 0);
        end

        run_cmd(2'b00, 0, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_tap   = 7'd20;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 50 && !bus.delay_move; i++) @(negedge clk);
        @(negedge clk);
        check("move_before_reset", int'(bus.delay_move), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_move_low", int'(bus.delay_move), 0);
        check("rst_loadn_low", int'(bus.delay_loadn), 0);
        check("rst_no_done", int'(bus.done), 0);
        @(negedge clk);
        boot_check();
        run_cmd(2'b10, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
